// File: rtl/mips_cpu_store_pkg.sv
// Shared opcodes, FSM state type and byte-lane helper for the MIPS store controller.
package mips_cpu_store_pkg;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    function automatic int lane_lo(input logic [1:0] k);
        return 24 - 8 * int'(k);
    endfunction

endpackage

// File: rtl/mips_cpu_store_merge.sv
// Combinational store merge: places rt bytes into big-endian lanes over the old word.
module mips_cpu_store_merge
    import mips_cpu_store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] reg_word,
    input  logic [1:0]  offset,
    input  logic [5:0]  insop,
    output logic [31:0] merged
);

    for (genvar j = 0; j < 4; j++) begin : g_lane
        localparam logic [1:0] LANE = 2'(j);
        localparam int         LO   = lane_lo(LANE);
        logic [7:0] lane_byte;

        always_comb begin
            lane_byte = old_word[LO +: 8];
            case (insop)
                OP_SW: lane_byte = reg_word[8*j +: 8];
                // Misaligned halfwords fault before WRITE, so offset is 0 or 2 here.
                OP_SH: begin
                    if (offset == LANE)              lane_byte = reg_word[7:0];
                    else if (offset + 2'd1 == LANE)  lane_byte = reg_word[15:8];
                end
                OP_SB: if (offset == LANE) lane_byte = reg_word[7:0];
                default: ;
            endcase
        end

        assign merged[LO +: 8] = lane_byte;
    end

endmodule

// File: rtl/mips_cpu_store_ctrl.sv
// SB/SH/SW sequencer: read-modify-write for sub-word stores, direct write for SW,
// stalling the core until the store retires or faults.
module mips_cpu_store_ctrl
    import mips_cpu_store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        insop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_waitrequest
);

    state_t              state, state_n;
    logic [5:0]          insop_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   reg_q;
    logic [DATA_W-1:0]   old_q;
    logic                fault_q;
    logic                bad_req;
    logic [DATA_W-1:0]   merged;

    always_comb begin
        case (insop)
            OP_SB:   bad_req = 1'b0;
            OP_SH:   bad_req = addr[0];
            OP_SW:   bad_req = (addr[1:0] != 2'b00);
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) begin
                if (bad_req)             state_n = DONE;
                else if (insop == OP_SW) state_n = WRITE;
                else                     state_n = READ;
            end
            READ:  if (!mem_waitrequest) state_n = WRITE;
            WRITE: if (!mem_waitrequest) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            insop_q <= '0;
            addr_q  <= '0;
            reg_q   <= '0;
            old_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                insop_q <= insop;
                addr_q  <= addr;
                reg_q   <= reg_data;
                fault_q <= bad_req;
            end
            if (state == READ && !mem_waitrequest) old_q <= mem_readdata;
            if (state == DONE) fault_q <= 1'b0;
        end
    end

    mips_cpu_store_merge u_merge (
        .old_word (old_q),
        .reg_word (reg_q),
        .offset   (addr_q[1:0]),
        .insop    (insop_q),
        .merged   (merged)
    );

    assign stall         = (state != IDLE);
    assign done          = (state == DONE);
    assign fault         = done & fault_q;
    assign mem_read      = (state == READ);
    assign mem_write     = (state == WRITE);
    assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_writedata = (state == WRITE) ? merged : '0;

endmodule

// File: doc/mips_cpu_store_ctrl.md
Name: mips_cpu_store_ctrl

Overview:
Sequences SB/SH/SW stores against the word-addressed Harvard data memory. Sub-word stores are done as read-modify-write; full-word stores are written directly. Register bytes are placed into big-endian byte lanes, and the block stalls the core until the store retires. It sits between the EX/MEM stage and the data-memory port and replaces any combinational store merge.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_address
- DATA_W, 32, data word width; fixed at 32, kept for port symmetry only

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- start  in  1  store request; sampled only in IDLE
- insop  in  6  opcode: 6'b101000 SB, 6'b101001 SH, 6'b101011 SW
- addr  in  32  effective byte address
- reg_data  in  32  rt register value
- stall  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the store retires or faults
- fault  out  1  valid with done: misaligned address or illegal insop
- mem_address  out  32  word address {addr_q[31:2],2'b00}
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- mem_writedata  out  32  merged store word
- mem_readdata  in  32  read data
- mem_waitrequest  in  1  memory not ready; hold all strobes and address stable

Behaviour:
- Reset values (after the first clk edge with reset high): state IDLE; stall, done, fault, mem_read, mem_write = 0; mem_address, mem_writedata = 0. Reset mid-operation aborts with no partial write; a pending write strobe drops at that edge.
- States: IDLE, READ, WRITE, DONE.
- IDLE with start=1: capture insop_q, addr_q, reg_q. Next state:
  - illegal insop, SH with addr[0]=1, or SW with addr[1:0]!=0 -> DONE with fault_q=1;
  - SW -> WRITE;
  - SB/SH -> READ.
- start is ignored in every state except IDLE.
- READ: mem_read=1. If mem_waitrequest=1, stay. Else capture old_q=mem_readdata and go to WRITE.
- WRITE: mem_write=1, mem_writedata=merge(old_q, reg_q, addr_q[1:0], insop_q). If mem_waitrequest=1, stay with data held. Else go to DONE.
- DONE: done=1; fault=fault_q; next state IDLE; fault_q cleared.
- Lane k (k = addr[1:0]) occupies bits [31-8k : 24-8k].
- SB: reg[7:0] goes to lane k; other lanes come from old_q.
- SH (k = 0 or 2): reg[7:0] goes to lane k, reg[15:8] to lane k+1; other lanes from old_q.
- SW: {reg[7:0], reg[15:8], reg[23:16], reg[31:24]}.
- mem_read and mem_write are never high together. Both strobes are 0 in IDLE and DONE.
- Latency with zero wait states, start high at edge 0:
  - SB/SH: READ in cycle 1, WRITE in cycle 2, done in cycle 3.
  - SW: WRITE in cycle 1, done in cycle 2.
  - Fault: done+fault in cycle 1.
  - Each wait-state cycle adds one cycle.
- Back-to-back: start may be high in the cycle after DONE (IDLE) and is accepted there.

Decomposition:
- Package mips_cpu_store_pkg:
  - opcode localparams OP_SB/OP_SH/OP_SW;
  - state enum {IDLE, READ, WRITE, DONE};
  - function lane_lo(k) returning bit index.
- Sub-module mips_cpu_store_merge: purely combinational (old, reg, offset[1:0], insop) -> merged word. It is instantiated once and unit-testable on its own.

Test Plan:
- SB, addr=0x100, reg=0x000000AB, readdata=0x11223344, no wait -> READ at 0x100, write 0xAB223344 in cycle 2, done in cycle 3, fault=0.
- SB, addr=0x103, reg=0xFF, readdata=0x11223344 -> write 0x112233FF. SH, addr=0x102, reg=0xBEEF, same readdata -> write 0x1122EFBE.
- SW, addr=0x200, reg=0x12345678 -> no read, write 0x78563412 in cycle 1, done in cycle 2.
- SH addr=0x101 and SW addr=0x202 -> done+fault in cycle 1, mem_read=mem_write=0 throughout. insop=6'b100011 -> fault likewise.
- SB with mem_waitrequest high for 3 cycles in READ and 2 in WRITE -> strobes and address held, done in cycle 8; start pulses while stall=1 are ignored.
- reset asserted in WRITE of an SB -> next cycle IDLE with all outputs 0, no done pulse; a following SW completes normally.
